// File: rtl/sim_halt_monitor.sv
// sim_halt_monitor
//   End-of-test monitor for RISC-V core simulations. Watches the retire
//   stream and data-memory store port. It declares the run finished on one of
//   three events:
//     - a self-loop halt: LOOP_REPEAT consecutive HALT_INSTR retires at one pc
//     - a tohost PASS/FAIL store
//     - a watchdog timeout
//   All outputs are registered. The monitor drives no core signal.
//
// Ports
//   clk          rising-edge clock
//   reset        synchronous, active-low reset
//   retire       an instruction retires this cycle
//   pc, instr    pc and encoding of the retiring instruction
//   mem_write    data-memory store strobe
//   data_adr     store address
//   write_data   store data
//   done         run finished (sticky until reset)
//   status       0 RUN, 1 HALT_LOOP, 2 PASS, 3 FAIL, 4 TIMEOUT
//   halt_pc      pc of the halt loop or of the reporting store
//   fail_code    write_data>>1 of a FAIL store, else 0
//   cycle_count  cycles spent in RUN (saturating)
//   retire_count retirements seen in RUN (saturating)

module sim_halt_monitor #(
  parameter int unsigned     XLEN           = 32,
  parameter int unsigned     CNT_W          = 32,
  parameter logic [XLEN-1:0] HALT_INSTR     = 32'h0000006f,
  parameter int              LOOP_REPEAT    = 2,
  parameter logic [XLEN-1:0] TOHOST_ADDR    = 32'h00000100,
  parameter int unsigned     TIMEOUT_CYCLES = 100000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             retire,
  input  logic [XLEN-1:0]  pc,
  input  logic [XLEN-1:0]  instr,
  input  logic             mem_write,
  input  logic [XLEN-1:0]  data_adr,
  input  logic [XLEN-1:0]  write_data,
  output logic             done,
  output logic [2:0]       status,
  output logic [XLEN-1:0]  halt_pc,
  output logic [XLEN-1:0]  fail_code,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] retire_count
);

  if (LOOP_REPEAT < 1) begin : g_bad_loop_repeat
    $error("sim_halt_monitor: LOOP_REPEAT must be >= 1");
  end

  localparam int unsigned REP_W = (LOOP_REPEAT < 2) ? 1 : $clog2(LOOP_REPEAT + 1);

  typedef enum logic [2:0] {
    ST_RUN       = 3'd0,
    ST_HALT_LOOP = 3'd1,
    ST_PASS      = 3'd2,
    ST_FAIL      = 3'd3,
    ST_TIMEOUT   = 3'd4
  } state_t;

  state_t            state;
  logic [REP_W-1:0]  rep;
  logic [REP_W-1:0]  rep_next;
  logic [XLEN-1:0]   last_pc;
  logic [CNT_W-1:0]  cyc_inc;
  logic              is_halt;
  logic              tohost_store;
  logic              pass_hit;
  logic              fail_hit;
  logic              loop_hit;
  logic              timeout_hit;

  assign status = state;

  assign is_halt      = retire && (instr == HALT_INSTR);
  assign tohost_store = retire && mem_write && (data_adr == TOHOST_ADDR);
  assign pass_hit     = tohost_store && (write_data == XLEN'(1));
  assign fail_hit     = tohost_store && write_data[0] && (write_data != XLEN'(1));
  assign cyc_inc      = (&cycle_count) ? cycle_count : cycle_count + 1'b1;
  assign timeout_hit  = (TIMEOUT_CYCLES != 0) && (cyc_inc == CNT_W'(TIMEOUT_CYCLES));

  // rep counts the current run of HALT_INSTR retires at a single pc; a halt
  // at a new pc starts a fresh run rather than clearing it.
  always_comb begin
    rep_next = rep;
    if (retire) begin
      if (instr == HALT_INSTR) begin
        if (rep == '0 || pc == last_pc) rep_next = rep + 1'b1;
        else                            rep_next = REP_W'(1);
      end else begin
        rep_next = '0;
      end
    end
  end

  assign loop_hit = is_halt && (rep_next == REP_W'(LOOP_REPEAT));

  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= ST_RUN;
      done         <= 1'b0;
      halt_pc      <= '0;
      fail_code    <= '0;
      cycle_count  <= '0;
      retire_count <= '0;
      rep          <= '0;
      last_pc      <= '0;
    end else if (state == ST_RUN) begin
      cycle_count <= cyc_inc;
      if (retire && !(&retire_count)) retire_count <= retire_count + 1'b1;
      rep <= rep_next;
      if (is_halt) last_pc <= pc;

      if (pass_hit) begin
        state   <= ST_PASS;
        done    <= 1'b1;
        halt_pc <= pc;
      end else if (fail_hit) begin
        state     <= ST_FAIL;
        done      <= 1'b1;
        halt_pc   <= pc;
        fail_code <= {1'b0, write_data[XLEN-1:1]};
      end else if (loop_hit) begin
        state   <= ST_HALT_LOOP;
        done    <= 1'b1;
        halt_pc <= pc;
      end else if (timeout_hit) begin
        state <= ST_TIMEOUT;
        done  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sim_halt_monitor.sv
// Bench for sim_halt_monitor: two instances (watchdog 50 and watchdog off)
// share one stimulus stream and are checked every cycle against a
// history-based reference model, plus directed literal checks.

module tb_sim_halt_monitor;

  localparam logic [31:0] HALT   = 32'h0000006f;
  localparam logic [31:0] ALU    = 32'h00000013;
  localparam logic [31:0] TOHOST = 32'h00000100;
  localparam int          NREP   = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        retire = 1'b0;
  logic        mem_write = 1'b0;
  logic [31:0] pc = '0, instr = '0, data_adr = '0, write_data = '0;

  logic        done_o   [2];
  logic [2:0]  status_o [2];
  logic [31:0] hpc_o    [2];
  logic [31:0] fc_o     [2];
  logic [31:0] cyc_o    [2];
  logic [31:0] ret_o    [2];

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  always #5 clk = ~clk;

  sim_halt_monitor #(.TIMEOUT_CYCLES(50)) dut (
    .clk(clk), .reset(reset), .retire(retire), .pc(pc), .instr(instr),
    .mem_write(mem_write), .data_adr(data_adr), .write_data(write_data),
    .done(done_o[0]), .status(status_o[0]), .halt_pc(hpc_o[0]),
    .fail_code(fc_o[0]), .cycle_count(cyc_o[0]), .retire_count(ret_o[0])
  );

  sim_halt_monitor #(.TIMEOUT_CYCLES(0)) dut_nowd (
    .clk(clk), .reset(reset), .retire(retire), .pc(pc), .instr(instr),
    .mem_write(mem_write), .data_adr(data_adr), .write_data(write_data),
    .done(done_o[1]), .status(status_o[1]), .halt_pc(hpc_o[1]),
    .fail_code(fc_o[1]), .cycle_count(cyc_o[1]), .retire_count(ret_o[1])
  );

  // ---------------- reference model ----------------
  // Loop detection is answered from the retire history: the run finishes
  // when the last NREP retires are all HALT at the same pc and this cycle
  // retired one of them.
  int unsigned tmo [2] = '{50, 0};
  logic [2:0]  m_st  [2];
  logic [31:0] m_hpc [2];
  logic [31:0] m_fc  [2];
  logic [31:0] m_cyc [2];
  logic [31:0] m_ret [2];
  bit          m_valid = 0;
  logic [31:0] hist_pc [$];
  logic [31:0] hist_in [$];

  always @(posedge clk) begin : model
    int run;
    logic [31:0] ncyc;
    logic store;
    if (!reset) begin
      for (int k = 0; k < 2; k++) begin
        m_st[k] <= 3'd0; m_hpc[k] <= '0; m_fc[k] <= '0;
        m_cyc[k] <= '0;  m_ret[k] <= '0;
      end
      hist_pc.delete();
      hist_in.delete();
      m_valid <= 1;
    end else if (m_valid) begin
      if (retire) begin
        hist_pc.push_back(pc);
        hist_in.push_back(instr);
        while (hist_pc.size() > 8) begin
          void'(hist_pc.pop_front());
          void'(hist_in.pop_front());
        end
      end
      run = 0;
      for (int i = hist_pc.size() - 1; i >= 0; i--) begin
        if (hist_in[i] == HALT && hist_pc[i] == hist_pc[hist_pc.size()-1]) run++;
        else break;
      end
      store = retire && mem_write && data_adr == TOHOST;
      for (int k = 0; k < 2; k++) begin
        if (m_st[k] == 3'd0) begin
          ncyc = (m_cyc[k] == 32'hFFFF_FFFF) ? m_cyc[k] : m_cyc[k] + 1;
          m_cyc[k] <= ncyc;
          if (retire && m_ret[k] != 32'hFFFF_FFFF) m_ret[k] <= m_ret[k] + 1;
          if (store && write_data == 32'd1) begin
            m_st[k] <= 3'd2; m_hpc[k] <= pc;
          end else if (store && write_data[0]) begin
            m_st[k] <= 3'd3; m_hpc[k] <= pc; m_fc[k] <= write_data >> 1;
          end else if (retire && instr == HALT && run >= NREP) begin
            m_st[k] <= 3'd1; m_hpc[k] <= pc;
          end else if (tmo[k] != 0 && ncyc == tmo[k]) begin
            m_st[k] <= 3'd4;
          end
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  task automatic cmp(input string name, input int k, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d] t=%0t: got %h expected %h", name, k, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (m_valid) begin
      for (int k = 0; k < 2; k++) begin
        cmp("status", k, {29'b0, status_o[k]}, {29'b0, m_st[k]});
        cmp("done", k, {31'b0, done_o[k]}, {31'b0, (m_st[k] != 3'd0)});
        cmp("halt_pc", k, hpc_o[k], m_hpc[k]);
        cmp("fail_code", k, fc_o[k], m_fc[k]);
        cmp("cycle_count", k, cyc_o[k], m_cyc[k]);
        cmp("retire_count", k, ret_o[k], m_ret[k]);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input logic r, input logic [31:0] p, input logic [31:0] i,
                       input logic mw, input logic [31:0] a, input logic [31:0] wd);
    @(negedge clk);
    reset = 1'b1; retire = r; pc = p; instr = i;
    mem_write = mw; data_adr = a; write_data = wd;
  endtask

  task automatic idle();
    drive(1'b0, '0, '0, 1'b0, '0, '0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0; retire = 1'b0; mem_write = 1'b0;
    pc = '0; instr = '0; data_adr = '0; write_data = '0;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    cmp(name, 0, act, exp);
  endtask

  initial begin
    do_reset();

    // 1: ALU stream then halt loop at 0x40
    for (int i = 0; i < 5; i++) drive(1, 32'h10 + 4*i, ALU, 0, '0, '0);
    drive(1, 32'h40, HALT, 0, '0, '0);
    drive(1, 32'h40, HALT, 0, '0, '0);
    chk("t1_not_done_yet", {31'b0, done_o[0]}, 32'd0);
    drive(1, 32'h40, HALT, 0, '0, '0);
    chk("t1_done", {31'b0, done_o[0]}, 32'd1);
    chk("t1_status", {29'b0, status_o[0]}, 32'd1);
    chk("t1_halt_pc", hpc_o[0], 32'h40);
    chk("t1_retire_count", ret_o[0], 32'd7);
    chk("t1_model_retires", m_ret[0], 32'd7);

    // 2: PASS at cycle 20, later halt loop ignored
    do_reset();
    for (int i = 0; i < 19; i++) drive(1, 32'h200 + 4*i, ALU, 0, '0, '0);
    drive(1, 32'h80, 32'h00a02023, 1, TOHOST, 32'd1);
    for (int i = 0; i < 3; i++) drive(1, 32'h40, HALT, 0, '0, '0);
    idle();
    chk("t2_status", {29'b0, status_o[0]}, 32'd2);
    chk("t2_halt_pc", hpc_o[0], 32'h80);
    chk("t2_cycles", cyc_o[0], 32'd20);
    chk("t2_retires", ret_o[0], 32'd20);

    // 3: even tohost value ignored, then FAIL code 3
    do_reset();
    drive(1, 32'h20, 32'h00a02023, 1, TOHOST, 32'h4);
    drive(1, 32'h24, 32'h00a02023, 1, TOHOST, 32'h7);
    chk("t3_even_ignored", {29'b0, status_o[0]}, 32'd0);
    idle();
    chk("t3_status", {29'b0, status_o[0]}, 32'd3);
    chk("t3_fail_code", fc_o[0], 32'h3);
    chk("t3_halt_pc", hpc_o[0], 32'h24);

    // 4: watchdog 50 fires, disabled watchdog keeps running
    do_reset();
    for (int i = 0; i < 49; i++) idle();
    idle();
    chk("t4_before_limit", {29'b0, status_o[0]}, 32'd0);
    idle();
    chk("t4_timeout", {29'b0, status_o[0]}, 32'd4);
    chk("t4_cycles", cyc_o[0], 32'd50);
    for (int i = 0; i < 10000 - 51; i++) idle();
    idle();
    chk("t4_nowd_status", {29'b0, status_o[1]}, 32'd0);
    chk("t4_nowd_cycles", cyc_o[1], 32'd10000);

    // 5: tohost beats loop in the same cycle; pc change breaks the loop
    do_reset();
    drive(1, 32'h40, HALT, 0, '0, '0);
    drive(1, 32'h40, HALT, 1, TOHOST, 32'd1);
    idle();
    chk("t5_priority", {29'b0, status_o[0]}, 32'd2);
    do_reset();
    drive(1, 32'h40, HALT, 0, '0, '0);
    drive(1, 32'h44, HALT, 0, '0, '0);
    idle();
    chk("t5_pc_mismatch", {29'b0, status_o[0]}, 32'd0);
    drive(1, 32'h44, HALT, 0, '0, '0);
    idle();
    chk("t5_new_run", {29'b0, status_o[0]}, 32'd1);
    chk("t5_new_run_pc", hpc_o[0], 32'h44);

    // 6: reset after PASS; bubbles inside a halt loop
    do_reset();
    drive(1, 32'h8, 32'h00a02023, 1, TOHOST, 32'd1);
    do_reset();
    idle();
    chk("t6_reset_status", {29'b0, status_o[0]}, 32'd0);
    chk("t6_reset_done", {31'b0, done_o[0]}, 32'd0);
    chk("t6_reset_halt_pc", hpc_o[0], 32'd0);
    drive(1, 32'h40, HALT, 0, '0, '0);
    for (int i = 0; i < 3; i++) idle();
    drive(1, 32'h40, HALT, 0, '0, '0);
    idle();
    chk("t6_bubbles", {29'b0, status_o[0]}, 32'd1);

    // random traffic against the model
    do_reset();
    for (int n = 0; n < 4000; n++) begin
      logic        r, mw;
      logic [31:0] p, i, a, wd;
      int unsigned sel;
      if ($urandom_range(0, 99) < 3) begin
        do_reset();
        continue;
      end
      r   = ($urandom_range(0, 3) != 0);
      sel = $urandom_range(0, 9);
      p   = (sel < 4) ? 32'h40 : (sel < 7) ? 32'h44 : ($urandom & 32'hFFC);
      i   = ($urandom_range(0, 9) < 5) ? HALT : (($urandom_range(0, 1) == 0) ? ALU : $urandom);
      mw  = ($urandom_range(0, 99) < 8);
      a   = ($urandom_range(0, 2) != 0) ? TOHOST : 32'h104;
      sel = $urandom_range(0, 2);
      wd  = (sel == 0) ? 32'd1 : (sel == 1) ? ($urandom | 32'd1) : ($urandom & ~32'd1);
      drive(r, p, i, mw, a, wd);
    end
    idle();
    idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
